arithmetic_logic_unit: RTL

- Execute-stage ALU. Consumes the 4-bit alu_control_signal produced by the ALU control decoder, together with two operands.
- Registers the result, zero flag and overflow flag into a valid/ready output stage with a 2-entry skid buffer, so EX can stall without dropping operations.
- Sits between ID/EX operand muxing and the EX/MEM pipeline register.
- Latency 1 cycle; throughput 1 op/cycle.

---
 rtl/arithmetic_logic_unit_pkg.sv | 38 +++
 rtl/arithmetic_logic_unit_core.sv | 73 +++++++
 rtl/arithmetic_logic_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/arithmetic_logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// arithmetic_logic_unit_pkg
// Shared definitions for the execute-stage ALU and the ALU control decoder.
// Holds the one opcode table used by both ends, the skid-buffer state encoding
// and a small helper that tells whether a control code is recognised.
// No ports: imported with "import arithmetic_logic_unit_pkg::*;".
// -----------------------------------------------------------------------------
package arithmetic_logic_unit_pkg;

   // ALU control codes emitted by the ALU control decoder
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;
   localparam logic [3:0] ALU_XOR = 4'b1101;

   // Occupancy of the output stage: main register M and skid register S
   typedef enum logic [1:0] {
      STATE_EMPTY = 2'd0,
      STATE_ONE   = 2'd1,
      STATE_FULL  = 2'd2
   } skid_state_e;

   // True for every control code the ALU implements
   function automatic logic is_legal_op(input logic [3:0] code);
      logic legal;
      legal = 1'b0;
      case (code)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
         ALU_SLT, ALU_NOR, ALU_XOR: legal = 1'b1;
         default:                   legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/arithmetic_logic_unit_core.sv
// -----------------------------------------------------------------------------
// arithmetic_logic_unit_core
// Purely combinational ALU datapath: computes the result and flags for one
// operation. No state; the enclosing stage registers the outputs.
// Ports:
//   alu_control_signal  in   4           operation code
//   operand_a           in   DATA_WIDTH  first operand (rs)
//   operand_b           in   DATA_WIDTH  second operand (rt / immediate)
//   result              out  DATA_WIDTH  operation result (0 for unknown codes)
//   zero                out  1           result == 0
//   overflow            out  1           signed overflow, ADD/SUB only
//   illegal             out  1           unrecognised control code
// -----------------------------------------------------------------------------
module arithmetic_logic_unit_core
   import arithmetic_logic_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [3:0]            alu_control_signal,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  zero,
   output logic                  overflow,
   output logic                  illegal
);

   localparam int MSB = DATA_WIDTH - 1;

   logic [DATA_WIDTH-1:0] sum;
   logic [DATA_WIDTH-1:0] diff;
   logic                  add_overflow;
   logic                  sub_overflow;
   logic                  less_than;

   // Shared adder/subtractor and their signed-overflow detection. Overflow on
   // add happens when both operands share a sign the sum does not; on subtract
   // when the operand signs differ and the difference takes b's sign.
   always_comb begin
      sum          = operand_a + operand_b;
      diff         = operand_a - operand_b;
      add_overflow = (operand_a[MSB] == operand_b[MSB]) && (sum[MSB] != operand_a[MSB]);
      sub_overflow = (operand_a[MSB] != operand_b[MSB]) && (diff[MSB] != operand_a[MSB]);
      // The raw sign of a-b is wrong exactly when the subtraction overflowed
      less_than    = diff[MSB] ^ sub_overflow;
   end

   // Operation select. Zero is taken from the selected result so that SLT,
   // logic ops and unknown codes all report it consistently.
   always_comb begin
      result   = '0;
      overflow = 1'b0;
      illegal  = 1'b0;
      case (alu_control_signal)
         ALU_ADD: begin
            result   = sum;
            overflow = add_overflow;
         end
         ALU_SUB: begin
            result   = diff;
            overflow = sub_overflow;
         end
         ALU_AND: result = operand_a & operand_b;
         ALU_OR:  result = operand_a | operand_b;
         ALU_XOR: result = operand_a ^ operand_b;
         ALU_NOR: result = ~(operand_a | operand_b);
         ALU_SLT: result = {{(DATA_WIDTH-1){1'b0}}, less_than};
         default: illegal = ~is_legal_op(alu_control_signal);
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/arithmetic_logic_unit.sv
// -----------------------------------------------------------------------------
// arithmetic_logic_unit
// Execute-stage ALU with a registered valid/ready output stage. A main output
// register M and a skid register S let the stage absorb one extra operation
// when downstream stalls, so in_ready can stay a pure register. Latency is one
// cycle and full throughput is sustained while out_ready stays high.
// Ports:
//   clock               in   1           rising-edge clock
//   reset_n             in   1           asynchronous active-low reset
//   in_valid            in   1           operation offered this cycle
//   in_ready            out  1           stage can accept (registered)
//   alu_control_signal  in   4           operation code
//   operand_a           in   DATA_WIDTH  first operand
//   operand_b           in   DATA_WIDTH  second operand
//   out_valid           out  1           result available
//   out_ready           in   1           downstream accepts result
//   result              out  DATA_WIDTH  registered result
//   zero                out  1           result == 0
//   overflow            out  1           signed overflow (ADD/SUB)
//   illegal             out  1           unrecognised control code
// -----------------------------------------------------------------------------
module arithmetic_logic_unit
   import arithmetic_logic_unit_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            alu_control_signal,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  zero,
   output logic                  overflow,
   output logic                  illegal
);

   skid_state_e state_q, state_d;

   logic [DATA_WIDTH-1:0] m_result_q, m_result_d;
   logic                  m_zero_q, m_zero_d;
   logic                  m_overflow_q, m_overflow_d;
   logic                  m_illegal_q, m_illegal_d;

   logic [DATA_WIDTH-1:0] s_result_q, s_result_d;
   logic                  s_zero_q, s_zero_d;
   logic                  s_overflow_q, s_overflow_d;
   logic                  s_illegal_q, s_illegal_d;

   logic                  in_ready_q, in_ready_d;

   logic [DATA_WIDTH-1:0] core_result;
   logic                  core_zero;
   logic                  core_overflow;
   logic                  core_illegal;

   logic                  accept;
   logic                  out_xfer;

   arithmetic_logic_unit_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_core (
      .alu_control_signal (alu_control_signal),
      .operand_a          (operand_a),
      .operand_b          (operand_b),
      .result             (core_result),
      .zero               (core_zero),
      .overflow           (core_overflow),
      .illegal            (core_illegal)
   );

   assign accept   = in_valid && in_ready_q;
   assign out_xfer = out_valid && out_ready;

   // State and payload registers. Reset empties both slots and clears the
   // visible payload, discarding anything that was buffered.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= STATE_EMPTY;
         in_ready_q   <= 1'b1;
         m_result_q   <= '0;
         m_zero_q     <= 1'b0;
         m_overflow_q <= 1'b0;
         m_illegal_q  <= 1'b0;
         s_result_q   <= '0;
         s_zero_q     <= 1'b0;
         s_overflow_q <= 1'b0;
         s_illegal_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         m_result_q   <= m_result_d;
         m_zero_q     <= m_zero_d;
         m_overflow_q <= m_overflow_d;
         m_illegal_q  <= m_illegal_d;
         s_result_q   <= s_result_d;
         s_zero_q     <= s_zero_d;
         s_overflow_q <= s_overflow_d;
         s_illegal_q  <= s_illegal_d;
      end
   end

   // Next-state logic for the occupancy FSM. in_ready for the next cycle is
   // derived from the next state, so it is registered and never looks at
   // out_ready combinationally.
   always_comb begin
      state_d = state_q;
      case (state_q)
         STATE_EMPTY: begin
            if (accept) state_d = STATE_ONE;
         end
         STATE_ONE: begin
            if (accept && !out_xfer)      state_d = STATE_FULL;
            else if (!accept && out_xfer) state_d = STATE_EMPTY;
         end
         STATE_FULL: begin
            if (out_xfer) state_d = STATE_ONE;
         end
         default: state_d = STATE_EMPTY;
      endcase
      in_ready_d = (state_d != STATE_FULL);
   end

   // Payload movement. M takes a fresh result when it is empty or is being
   // drained in the same cycle; otherwise a fresh result parks in S. When
   // FULL drains, S moves up into M so order is preserved. Slots only load on
   // a real accept, so undriven operands never reach the outputs.
   always_comb begin
      m_result_d   = m_result_q;
      m_zero_d     = m_zero_q;
      m_overflow_d = m_overflow_q;
      m_illegal_d  = m_illegal_q;
      s_result_d   = s_result_q;
      s_zero_d     = s_zero_q;
      s_overflow_d = s_overflow_q;
      s_illegal_d  = s_illegal_q;
      if (accept && ((state_q == STATE_EMPTY) || ((state_q == STATE_ONE) && out_xfer))) begin
         m_result_d   = core_result;
         m_zero_d     = core_zero;
         m_overflow_d = core_overflow;
         m_illegal_d  = core_illegal;
      end else if (accept && (state_q == STATE_ONE) && !out_xfer) begin
         s_result_d   = core_result;
         s_zero_d     = core_zero;
         s_overflow_d = core_overflow;
         s_illegal_d  = core_illegal;
      end else if ((state_q == STATE_FULL) && out_xfer) begin
         m_result_d   = s_result_q;
         m_zero_d     = s_zero_q;
         m_overflow_d = s_overflow_q;
         m_illegal_d  = s_illegal_q;
      end
   end

   // Outputs: valid follows occupancy directly, so an asynchronous reset
   // drops it at once; the payload always comes from M.
   always_comb begin
      out_valid = (state_q != STATE_EMPTY);
      in_ready  = in_ready_q;
      result    = m_result_q;
      zero      = m_zero_q;
      overflow  = m_overflow_q;
      illegal   = m_illegal_q;
   end

endmodule
